// File: rtl/operand_collector_pkg.sv
// Operand collector shared constants and entry layout.
// Build with OPERAND_COLLECTOR_BYPASS_EN for write-port forwarding/snooping.
package operand_collector_pkg;

  localparam int SEL_W_DEF  = 18;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 8;
  localparam int DEPTH_DEF  = 4;

  typedef struct packed {
    logic [SEL_W_DEF-1:0]  rs1;
    logic [SEL_W_DEF-1:0]  rs2;
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [TAG_W_DEF-1:0]  tag;
  } entry_t;

endpackage

// File: rtl/operand_collector_if.sv
// Issue, register-file, write-port and functional-unit bundle of the
// operand collector.
interface operand_collector_if
  import operand_collector_pkg::*;
#(
  parameter int SEL_W  = SEL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) ();

  localparam int CW = $clog2(DEPTH + 1);

  logic              req_valid;
  logic              req_ready;
  logic [SEL_W-1:0]  req_rs1;
  logic [SEL_W-1:0]  req_rs2;
  logic [TAG_W-1:0]  req_tag;
  logic [SEL_W-1:0]  rf_rsel1;
  logic [SEL_W-1:0]  rf_rsel2;
  logic [DATA_W-1:0] rf_rdat1;
  logic [DATA_W-1:0] rf_rdat2;
  logic              wb_wen;
  logic [SEL_W-1:0]  wb_wsel;
  logic [DATA_W-1:0] wb_wdat;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [TAG_W-1:0]  op_tag;
  logic [CW-1:0]     count;

  modport master (
    output req_valid, req_rs1, req_rs2, req_tag,
    output rf_rdat1, rf_rdat2,
    output wb_wen, wb_wsel, wb_wdat,
    output op_ready,
    input  req_ready, rf_rsel1, rf_rsel2,
    input  op_valid, op_a, op_b, op_tag, count
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_tag,
    input  rf_rdat1, rf_rdat2,
    input  wb_wen, wb_wsel, wb_wdat,
    input  op_ready,
    output req_ready, rf_rsel1, rf_rsel2,
    output op_valid, op_a, op_b, op_tag, count
  );

endinterface

// File: rtl/opcol_entry.sv
// One collector slot: load, valid tracking and (with
// OPERAND_COLLECTOR_BYPASS_EN) write-port forwarding and snooping.
module opcol_entry
  import operand_collector_pkg::*;
#(
  parameter int SEL_W  = SEL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [SEL_W-1:0]  rs1_i,
  input  logic [SEL_W-1:0]  rs2_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              wb_wen_i,
  input  logic [SEL_W-1:0]  wb_wsel_i,
  input  logic [DATA_W-1:0] wb_wdat_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [TAG_W-1:0]  tag_o
);

  logic              valid_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [TAG_W-1:0]  tag_q;

`ifdef OPERAND_COLLECTOR_BYPASS_EN
  logic [SEL_W-1:0] rs1_q;
  logic [SEL_W-1:0] rs2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      rs1_q   <= rs1_i;
      rs2_q   <= rs2_i;
      a_q     <= (wb_wen_i && wb_wsel_i == rs1_i)
                 ? wb_wdat_i : a_i;
      b_q     <= (wb_wen_i && wb_wsel_i == rs2_i)
                 ? wb_wdat_i : b_i;
      tag_q   <= tag_i;
    end else begin
      if (clr_i)
        valid_q <= 1'b0;
      // A popped entry already left with its old value
      if (valid_q && wb_wen_i && wb_wsel_i == rs1_q)
        a_q <= wb_wdat_i;
      if (valid_q && wb_wen_i && wb_wsel_i == rs2_q)
        b_q <= wb_wdat_i;
    end
  end
`else
  logic unused_snoop;
  assign unused_snoop = ^{rs1_i, rs2_i,
                          wb_wen_i, wb_wsel_i,
                          wb_wdat_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      a_q     <= a_i;
      b_q     <= b_i;
      tag_q   <= tag_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end
`endif

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/operand_collector.sv
// In-order operand collector FIFO in front of a functional unit.
// OPERAND_COLLECTOR_BYPASS_EN enables write-port forwarding/snooping.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int SEL_W  = SEL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic CLK,
  input  logic nRST,
  operand_collector_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  logic [DEPTH-1:0]  vld_w;
  logic [DATA_W-1:0] a_w   [DEPTH];
  logic [DATA_W-1:0] b_w   [DEPTH];
  logic [TAG_W-1:0]  tag_w [DEPTH];

  assign bus.rf_rsel1  = bus.req_rs1;
  assign bus.rf_rsel2  = bus.req_rs2;
  assign bus.req_ready = cnt_q != CW'(DEPTH);
  assign bus.op_valid  = vld_w[head_q];
  assign bus.op_a      = a_w[head_q];
  assign bus.op_b      = b_w[head_q];
  assign bus.op_tag    = tag_w[head_q];
  assign bus.count     = cnt_q;

  assign push = bus.req_valid && bus.req_ready;
  assign pop  = bus.op_valid && bus.op_ready;

  always_comb begin
    head_d = pop  ? head_q + PW'(1) : head_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    opcol_entry #(
      .SEL_W  (SEL_W),
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
    ) u_ent (
      .clk_i     (CLK),
      .rst_ni    (nRST),
      .load_i    (push && tail_q == PW'(i)),
      .clr_i     (pop && head_q == PW'(i)),
      .rs1_i     (bus.req_rs1),
      .rs2_i     (bus.req_rs2),
      .a_i       (bus.rf_rdat1),
      .b_i       (bus.rf_rdat2),
      .tag_i     (bus.req_tag),
      .wb_wen_i  (bus.wb_wen),
      .wb_wsel_i (bus.wb_wsel),
      .wb_wdat_i (bus.wb_wdat),
      .valid_o   (vld_w[i]),
      .a_o       (a_w[i]),
      .b_o       (b_w[i]),
      .tag_o     (tag_w[i])
    );
  end

endmodule

// File: doc/operand_collector.md
OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 SHALL have parameter SEL_W, default 18: register select width, matching the register file select width.
REQ-002 SHALL have parameter DATA_W, default 32: register data width.
REQ-003 SHALL have parameter TAG_W, default 8: issue tag width.
REQ-004 SHALL have parameter DEPTH, default 4: collector entries (power of 2, >=2).
REQ-005 SHALL have ports as follows (one clock; reset asynchronous, active-low):
  CLK  in  1  clock
  nRST  in  1  asynchronous active-low reset
  req_valid  in  1  issue request valid
  req_ready  out  1  collector can accept
  req_rs1, req_rs2  in  SEL_W  source selects
  req_tag  in  TAG_W  issue tag
  rf_rsel1, rf_rsel2  out  SEL_W  register file read selects
  rf_rdat1, rf_rdat2  in  DATA_W  register file read data (combinational)
  wb_wen  in  1  write-port enable (snoop)
  wb_wsel  in  SEL_W  write-port select
  wb_wdat  in  DATA_W  write-port data
  op_valid  out  1  operand bundle valid
  op_ready  in  1  functional unit accepts
  op_a, op_b  out  DATA_W  collected operands
  op_tag  out  TAG_W  tag of head entry
  count  out  $clog2(DEPTH+1)  occupied entries

Function
REQ-006 SHALL drive rf_rsel1=req_rs1 and rf_rsel2=req_rs2 combinationally.
REQ-007 SHALL assert req_ready iff count<DEPTH; no pass-through when full.
REQ-008 On accept (req_valid&&req_ready), SHALL write {rs1,rs2,rf_rdat1,rf_rdat2,tag} into the tail entry at the next edge.
REQ-009 SHALL behave as an in-order FIFO; op_valid=count!=0; op_a/op_b/op_tag reflect the registered head entry.
REQ-010 Latency: accept in cycle N into an empty collector SHALL give op_valid=1 in cycle N+1.
REQ-011 Pop on op_valid&&op_ready; simultaneous push and pop SHALL leave count unchanged and be legal when full only if req_ready was already 1 (i.e. never when full).
REQ-012 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-013 op_ready with op_valid=0 and req_valid with req_ready=0 SHALL be ignored.
REQ-014 Outputs SHALL hold stable while op_valid&&!op_ready, except operand updates under REQ-019.

Reset
REQ-015 nRST low SHALL asynchronously clear count, pointers, op_valid, op_a, op_b, op_tag, and all entry valid bits to 0.
REQ-016 Reset asserted mid-operation SHALL discard all pending entries; no entry SHALL be output after reset release until a new accept.

Configuration
REQ-017 Macro OPERAND_COLLECTOR_BYPASS_EN SHALL compile in write-port forwarding and snooping.
REQ-018 With the macro: on accept, if wb_wen&&wb_wsel==req_rsN, the captured operand N SHALL be wb_wdat instead of rf_rdatN (both operands if rs1==rs2).
REQ-019 With the macro: each cycle wb_wen=1, every occupied entry whose rsN==wb_wsel SHALL have operand N replaced with wb_wdat at the next edge; an entry popped in the same cycle SHALL leave with its pre-update value.
REQ-020 Without the macro: operands SHALL be exactly rf_rdat1/rf_rdat2 at accept; wb_* SHALL be ignored and rs selects need not be stored.

Structure
REQ-021 Package operand_collector_pkg SHALL hold default SEL_W/DATA_W/TAG_W/DEPTH constants and the entry struct typedef {rs1, rs2, a, b, tag}.
REQ-022 Sub-module opcol_entry SHALL hold one entry with load, snoop compare, and update logic; operand_collector SHALL instantiate DEPTH copies plus the pointer/count logic.

Verification
REQ-023 Empty, accept rs1=5, rs2=9, rdat=0x11/0x22, tag=0x3 with op_ready=1 -> next cycle op_valid=1, op_a=0x11, op_b=0x22, op_tag=0x3; following cycle count=0.
REQ-024 Four accepts with op_ready=0 -> count=4, req_ready=0; fifth request stalls; set op_ready=1 -> tags pop in order 0,1,2,3 and the fifth is accepted once req_ready=1.
REQ-025 BYPASS_EN: accept rs1=7 with wb_wen=1, wb_wsel=7, wb_wdat=0xDEAD, rdat1=0x1 -> op_a=0xDEAD.
REQ-026 BYPASS_EN: entry rs2=3 held with op_ready=0, then a write to 3 of 0xBEEF -> op_b=0xBEEF next cycle; without the macro op_b unchanged.
REQ-027 Three entries pending, nRST pulsed low mid-cycle -> op_valid=0, count=0 immediately; no stale tag appears after release.
REQ-028 Continuous push+pop for 10 cycles at count=2 -> count stays 2, pointers wrap, tags emerge in issue order.
